adc_scheduler: RTL and testbench
================================

ADC_SCHEDULER -- requirements
Module: adc_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of sample requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, meaning the max clk cycles per wait state before abort.
REQ-003 The block SHALL have parameter RECAL_PERIOD, default 1024, meaning completed samples between automatic recalibrations.
REQ-004 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port req  input  NUM_REQ  level sample request per requester, held until its gnt.
REQ-007 The block SHALL have port recal_req  input  1  one-cycle recalibration request pulse.
REQ-008 The block SHALL have port adc_busy  input  1  ADC conversion/calibration in progress.
REQ-009 The block SHALL have port adc_value  input  12  ADC conversion result, valid when adc_busy falls.
REQ-010 The block SHALL have port adc_read  output  1  one-cycle conversion start pulse to ADC.
REQ-011 The block SHALL have port adc_recal  output  1  one-cycle recalibration start pulse to ADC.
REQ-012 The block SHALL have port gnt  output  NUM_REQ  one-hot one-cycle pulse marking the served requester.
REQ-013 The block SHALL have port data  output  12  captured sample, held until next capture.
REQ-014 The block SHALL have port data_valid  output  1  one-cycle pulse, coincident with gnt.
REQ-015 The block SHALL have port timeout_err  output  1  one-cycle pulse on any wait-state timeout.
REQ-016 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, SAMPLE_ACK, SAMPLE_DONE, RECAL_ACK, RECAL_DONE; all outputs registered.
REQ-018 IDLE with recal pending (latched recal_req or sample count = RECAL_PERIOD): adc_recal pulse next cycle, -> RECAL_ACK; recal SHALL take priority over req.
REQ-019 IDLE with no recal pending and req != 0: select requester round-robin, store index, adc_read pulse next cycle, -> SAMPLE_ACK.
REQ-020 Round-robin: search starts at (last served index + 1) mod NUM_REQ; after reset the search starts at 0.
REQ-021 SAMPLE_ACK/RECAL_ACK: wait for adc_busy = 1, then -> SAMPLE_DONE/RECAL_DONE; wait timer cleared on each state entry.
REQ-022 SAMPLE_DONE: on adc_busy = 0, data <= adc_value, gnt[idx] and data_valid pulse one cycle, sample count +1, -> IDLE.
REQ-023 RECAL_DONE: on adc_busy = 0, clear sample count and recal pending latch, -> IDLE; no gnt, no data_valid.
REQ-024 Timeout: if any wait state reaches TIMEOUT cycles, timeout_err pulses one cycle, -> IDLE, no gnt, data unchanged.
REQ-025 Sample timeout SHALL still advance the round-robin pointer past the aborted requester; recal timeout SHALL keep recal pending.
REQ-026 recal_req arriving in any state SHALL set the pending latch; repeated requests before service SHALL merge into one.
REQ-027 Sample count SHALL saturate at RECAL_PERIOD.
REQ-028 A requester deasserting req before gnt SHALL still receive its gnt for an in-flight conversion.
REQ-029 Minimum sample latency: req high in IDLE at cycle t -> adc_read at t+1.

Reset
REQ-030 Reset SHALL force IDLE from any state, including mid-conversion, without issuing adc_read or adc_recal.
REQ-031 Reset values: adc_read, adc_recal, gnt, data_valid, timeout_err, busy = 0; data = 0; sample count = 0; pointer = 0; recal pending = 1 (first action after reset is a recalibration).

Verification
REQ-032 Post-reset, req=4'b0001 -> adc_recal before any adc_read; after recal, adc_read then gnt=4'b0001 with data equal to adc_value.
REQ-033 req=4'b1111 held, ADC model returns 0x100+index -> gnt order 0001,0010,0100,1000,0001.
REQ-034 recal_req pulsed during SAMPLE_DONE -> sample completes with gnt, then adc_recal; no second recal for a doubled pulse.
REQ-035 adc_busy stuck low after adc_read, TIMEOUT=64 -> timeout_err at cycle 64, no gnt, next grant goes to the following requester.
REQ-036 RECAL_PERIOD=4, continuous req -> adc_recal after every 4th data_valid.
REQ-037 reset asserted in SAMPLE_DONE -> next cycle all outputs at reset values; busy=0.

Source files
------------

// File: rtl/adc_scheduler.sv
// Sample/recalibration scheduler for a single shared ADC. Requesters are served
// round-robin; recalibration (requested or periodic) always wins over samples.
// Every wait state is guarded by a timeout that aborts back to idle.
module adc_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned RECAL_PERIOD = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               recal_req,
  input  logic               adc_busy,
  input  logic [11:0]        adc_value,
  output logic               adc_read,
  output logic               adc_recal,
  output logic [NUM_REQ-1:0] gnt,
  output logic [11:0]        data,
  output logic               data_valid,
  output logic               timeout_err,
  output logic               busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam int unsigned CntW = $clog2(RECAL_PERIOD + 1);

  typedef enum logic [2:0] {
    StIdle,
    StSampleAck,
    StSampleDone,
    StRecalAck,
    StRecalDone
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q;    // first index searched on the next pick
  logic [IdxW-1:0]   idx_q;    // requester owning the in-flight conversion
  logic [TmrW-1:0]   tmr_q;
  logic [CntW-1:0]   cnt_q;
  logic              pend_q;

  logic              sel_found;
  logic [IdxW-1:0]   sel_idx;
  logic [IdxW-1:0]   sel_next;
  logic              recal_due;
  logic              expired;

  assign recal_due = pend_q || (cnt_q == CntW'(RECAL_PERIOD));
  assign expired   = (tmr_q == TmrW'(TIMEOUT - 1));
  assign sel_next  = (sel_idx == IdxW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;

  // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!sel_found && req[IdxW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(cand);
      end
    end
  end

  // Control FSM with registered pulse outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      idx_q       <= '0;
      tmr_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b1;  // first action after reset is a recalibration
      adc_read    <= 1'b0;
      adc_recal   <= 1'b0;
      gnt         <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      adc_read    <= 1'b0;
      adc_recal   <= 1'b0;
      gnt         <= '0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
      tmr_q       <= tmr_q + 1'b1;
      if (recal_req) begin
        pend_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          tmr_q <= '0;
          if (recal_due) begin
            adc_recal <= 1'b1;
            busy      <= 1'b1;
            state_q   <= StRecalAck;
          end else if (sel_found) begin
            adc_read <= 1'b1;
            busy     <= 1'b1;
            idx_q    <= sel_idx;
            // Advancing at selection also covers the aborted-sample case.
            ptr_q    <= sel_next;
            state_q  <= StSampleAck;
          end
        end
        StSampleAck, StRecalAck: begin
          if (adc_busy) begin
            tmr_q   <= '0;
            state_q <= (state_q == StSampleAck) ? StSampleDone : StRecalDone;
          end else if (expired) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StSampleDone: begin
          if (!adc_busy) begin
            data       <= adc_value;
            gnt        <= {{(NUM_REQ - 1){1'b0}}, 1'b1} << idx_q;
            data_valid <= 1'b1;
            if (cnt_q != CntW'(RECAL_PERIOD)) begin
              cnt_q <= cnt_q + 1'b1;
            end
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (expired) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StRecalDone: begin
          if (!adc_busy) begin
            cnt_q   <= '0;
            // A request landing on the completion cycle is kept, not lost.
            pend_q  <= recal_req;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (expired) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scheduler.sv
// Directed bench for adc_scheduler with a small ADC responder model and an
// event log of output pulses used to check ordering.
module tb_adc_scheduler;

  localparam int unsigned NReq = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NReq-1:0] req = '0;
  logic            recal_req = 1'b0;
  logic            adc_busy = 1'b0;
  logic [11:0]     adc_value = '0;
  logic            adc_read;
  logic            adc_recal;
  logic [NReq-1:0] gnt;
  logic [11:0]     data;
  logic            data_valid;
  logic            timeout_err;
  logic            busy;

  int checks = 0;
  int failures = 0;

  // Event codes: 1 recal start, 2 read start, 3 timeout, 100+gnt grant.
  int          log_q[$];
  logic [11:0] data_q[$];
  int          gnt_count = 0;

  logic model_en = 1'b1;
  int   busy_left = 0;
  int   conv_n = 0;

  adc_scheduler #(
    .NUM_REQ     (NReq),
    .TIMEOUT     (64),
    .RECAL_PERIOD(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .recal_req  (recal_req),
    .adc_busy   (adc_busy),
    .adc_value  (adc_value),
    .adc_read   (adc_read),
    .adc_recal  (adc_recal),
    .gnt        (gnt),
    .data       (data),
    .data_valid (data_valid),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ADC model: busy for three half-cycle-aligned ticks, value 0x100 + (n mod 4).
  always @(negedge clk) begin
    if (reset) begin
      adc_busy  = 1'b0;
      busy_left = 0;
      conv_n    = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) adc_busy = 1'b0;
    end else if (model_en && adc_read) begin
      adc_busy  = 1'b1;
      busy_left = 3;
      adc_value = 12'h100 + 12'(conv_n % 4);
      conv_n++;
    end else if (model_en && adc_recal) begin
      adc_busy  = 1'b1;
      busy_left = 3;
    end
  end

  // Pulse monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (adc_recal)   log_q.push_back(1);
      if (adc_read)    log_q.push_back(2);
      if (timeout_err) log_q.push_back(3);
      if (gnt != '0) begin
        log_q.push_back(100 + int'(gnt));
        data_q.push_back(data);
        gnt_count++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_adc_read"}, 32'(adc_read), 0);
    check({tag, "_adc_recal"}, 32'(adc_recal), 0);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_data_valid"}, 32'(data_valid), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_data"}, 32'(data), 0);
  endtask

  task automatic do_reset(input string tag);
    reset     = 1'b1;
    req       = '0;
    recal_req = 1'b0;
    model_en  = 1'b1;
    tick();
    tick();
    check_reset_outputs(tag);
    reset = 1'b0;
  endtask

  task automatic wait_gnts(input string tag, input int target, input int budget);
    int n = 0;
    while (gnt_count < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(gnt_count), 32'(target));
  endtask

  task automatic wait_read(input string tag, input int budget);
    int n = 0;
    while (!adc_read && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(adc_read), 1);
  endtask

  task automatic check_code(input string tag, input int idx, input int exp);
    if (idx < log_q.size()) check(tag, 32'(log_q[idx]), 32'(exp));
    else check(tag, 32'hFFFF_FFFF, 32'(exp));
  endtask

  initial begin
    int base;
    int gbase;
    int n;
    int exp_q[$];

    // Recal first after reset, then one sample to requester 0.
    do_reset("a_rst");
    base  = log_q.size();
    gbase = gnt_count;
    req   = 4'b0001;
    wait_gnts("a_wait", gbase + 1, 200);
    req = '0;
    check_code("a_first_recal", base, 1);
    check_code("a_then_read", base + 1, 2);
    check_code("a_gnt0", base + 2, 101);
    if (gbase < data_q.size()) check("a_data", 32'(data_q[gbase]), 32'h100);
    else check("a_data", 32'hFFFF_FFFF, 32'h100);

    // All requesters held: round-robin order plus recal after every 4th sample.
    do_reset("b_rst");
    base  = log_q.size();
    gbase = gnt_count;
    req   = 4'b1111;
    wait_gnts("b_wait", gbase + 9, 1500);
    req = '0;
    exp_q.delete();
    exp_q.push_back(1);
    for (int k = 0; k < 9; k++) begin
      if (k == 4 || k == 8) exp_q.push_back(1);
      exp_q.push_back(2);
      exp_q.push_back(100 + (1 << (k % 4)));
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      check_code($sformatf("b_code%0d", i), base + i, exp_q[i]);
    end
    for (int k = 0; k < 9; k++) begin
      if (gbase + k < data_q.size())
        check($sformatf("b_data%0d", k), 32'(data_q[gbase + k]), 32'h100 + 32'(k % 4));
    end

    // recal_req twice during SAMPLE_DONE: sample finishes, then exactly one recal.
    do_reset("c_rst");
    repeat (20) tick();
    base  = log_q.size();
    gbase = gnt_count;
    req   = 4'b0001;
    wait_read("c_read", 50);
    tick();
    recal_req = 1'b1;
    tick();
    recal_req = 1'b0;
    tick();
    recal_req = 1'b1;
    tick();
    recal_req = 1'b0;
    wait_gnts("c_wait", gbase + 1, 50);
    req = '0;
    repeat (40) tick();
    check_code("c_read_first", base, 2);
    check_code("c_gnt", base + 1, 101);
    check_code("c_recal_after", base + 2, 1);
    check("c_event_count", 32'(log_q.size() - base), 3);

    // ADC stuck idle: timeout 64 cycles after adc_read, next pick is requester 1.
    do_reset("d_rst");
    repeat (20) tick();
    base     = log_q.size();
    gbase    = gnt_count;
    model_en = 1'b0;
    req      = 4'b0011;
    wait_read("d_read", 50);
    n = 0;
    while (!timeout_err && n < 200) begin
      tick();
      n++;
    end
    check("d_timeout_cycles", 32'(n), 64);
    check("d_no_gnt", 32'(gnt_count), 32'(gbase));
    check("d_data_kept", 32'(data), 0);
    model_en = 1'b1;
    wait_gnts("d_wait", gbase + 1, 100);
    req = '0;
    check_code("d_seq_read", base, 2);
    check_code("d_seq_timeout", base + 1, 3);
    check_code("d_seq_read2", base + 2, 2);
    check_code("d_gnt1", base + 3, 102);
    check("d_data_new", 32'(data), 32'h100);
    repeat (5) tick();

    // Reset in SAMPLE_DONE: outputs clear next cycle, recal comes first again.
    base = log_q.size();
    req  = 4'b0001;
    wait_read("e_read", 50);
    tick();
    check("e_in_done_busy", 32'(busy), 1);
    reset = 1'b1;
    tick();
    check_reset_outputs("e_rst");
    reset = 1'b0;
    req   = '0;
    repeat (20) tick();
    check_code("e_pre_read", base, 2);
    check_code("e_recal_first", base + 1, 1);
    check("e_event_count", 32'(log_q.size() - base), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
